// File: rtl/bus_transfer_ctrl.sv
// bus_transfer_ctrl: DATA bus master sequencing drive/latch strobes
// with a dead-cycle turnaround between transfers.
module bus_transfer_ctrl #(
  parameter int NUM_REGS    = 8,
  parameter int WIDTH       = 16,
  parameter int DEAD_CYCLES = 1,
  localparam int SW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SW-1:0]       req_src,
  input  logic                req_imm_en,
  input  logic [WIDTH-1:0]    req_imm,
  input  logic [NUM_REGS-1:0] req_dst_mask,
  inout  wire  [WIDTH-1:0]    DATA,
  output logic [NUM_REGS-1:0] reg_enable,
  output logic [NUM_REGS-1:0] reg_latch,
  output logic [WIDTH-1:0]    bus_snoop,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int CW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [CW-1:0] DLAST = CW'(DEAD_CYCLES - 1);
  localparam logic [SW:0] NREG = (SW+1)'(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE, S_DRIVE, S_LATCH, S_TURN
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_dead;
  logic [SW-1:0]       r_src;
  logic                r_imm_en;
  logic [WIDTH-1:0]    r_imm;
  logic [NUM_REGS-1:0] r_mask;
  logic [NUM_REGS-1:0] r_enable;
  logic [NUM_REGS-1:0] r_latch;
  logic                r_drv;
  logic [WIDTH-1:0]    r_snoop;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  state_t              w_state_nxt;
  logic [CW-1:0]       w_dead_nxt;
  logic                w_accept;
  logic [SW-1:0]       w_src;
  logic                w_imm_en;
  logic [NUM_REGS-1:0] w_mask;
  logic                w_src_ok;
  logic                w_reg_src;
  logic [NUM_REGS-1:0] w_onehot;
  logic                w_active;
  logic [NUM_REGS-1:0] w_enable_nxt;
  logic [NUM_REGS-1:0] w_latch_nxt;
  logic                w_drv_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_err_nxt;

  assign req_ready = (r_state == S_IDLE);
  assign w_accept  = req_valid && req_ready;

  // Source/mask for the coming cycle: live inputs on accept, else captured.
  assign w_src     = w_accept ? req_src      : r_src;
  assign w_imm_en  = w_accept ? req_imm_en   : r_imm_en;
  assign w_mask    = w_accept ? req_dst_mask : r_mask;
  assign w_src_ok  = ({1'b0, w_src} < NREG);
  assign w_reg_src = !w_imm_en && w_src_ok;
  assign w_onehot  = NUM_REGS'(1) << w_src;

  // State register and turnaround counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_dead  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dead  <= w_dead_nxt;
    end
  end

  // Next-state: fixed DRIVE/LATCH, then DEAD_CYCLES of TURN.
  always_comb begin
    w_state_nxt = r_state;
    w_dead_nxt  = '0;
    unique case (r_state)
      S_IDLE:  if (req_valid) w_state_nxt = S_DRIVE;
      S_DRIVE: w_state_nxt = S_LATCH;
      S_LATCH: w_state_nxt = S_TURN;
      S_TURN: begin
        if (r_dead == DLAST) w_state_nxt = S_IDLE;
        else w_dead_nxt = r_dead + 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode for the next state; registered below so strobes are clean.
  always_comb begin
    w_active     = (w_state_nxt == S_DRIVE) ||
                   (w_state_nxt == S_LATCH);
    w_enable_nxt = (w_active && w_reg_src) ? w_onehot : '0;
    w_drv_nxt    = w_active && w_imm_en;
    w_latch_nxt  = '0;
    if (w_state_nxt == S_LATCH) begin
      if (w_imm_en)       w_latch_nxt = w_mask;
      else if (w_src_ok)  w_latch_nxt = w_mask & ~w_onehot;
    end
    w_busy_nxt   = (w_state_nxt != S_IDLE);
    w_done_nxt   = (w_state_nxt == S_TURN) &&
                   (w_dead_nxt == DLAST);
    w_err_nxt    = w_done_nxt && !w_imm_en && !w_src_ok;
  end

  // Request capture; later input changes are ignored until IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_src    <= '0;
      r_imm_en <= 1'b0;
      r_imm    <= '0;
      r_mask   <= '0;
    end else if (w_accept) begin
      r_src    <= req_src;
      r_imm_en <= req_imm_en;
      r_imm    <= req_imm;
      r_mask   <= req_dst_mask;
    end
  end

  // Registered strobes, status and bus snoop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_enable <= '0;
      r_latch  <= '0;
      r_drv    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_snoop  <= '0;
    end else begin
      r_enable <= w_enable_nxt;
      r_latch  <= w_latch_nxt;
      r_drv    <= w_drv_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      if (r_state == S_LATCH && (w_imm_en || w_src_ok))
        r_snoop <= DATA;
    end
  end

  assign DATA       = r_drv ? r_imm : {WIDTH{1'bz}};
  assign reg_enable = r_enable;
  assign reg_latch  = r_latch;
  assign bus_snoop  = r_snoop;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// tb_bus_transfer_ctrl: directed bench with bus register models,
// a done-time scoreboard and a bus contention monitor.
module tb_bus_transfer_ctrl;

  typedef struct {
    logic        err;
    logic [15:0] snoop;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic valid_a, valid_b, valid_c;
  logic [2:0] src;
  logic imm_en;
  logic [15:0] imm;
  logic [7:0] mask;
  logic keep_a;

  wire [15:0] data_a, data_b, data_c;
  logic ready_a, ready_b, ready_c;
  logic [7:0] en_a, lat_a, en_c, lat_c;
  logic [5:0] en_b, lat_b;
  logic [15:0] snoop_a, snoop_b, snoop_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;
  logic err_a, err_b, err_c;

  logic [7:0][15:0] ra, rb, rc;

  exp_t sbq[$];
  int n_chk = 0;
  int n_fail = 0;
  int viol = 0;

  always #5 clk = ~clk;

  bus_transfer_ctrl #(.NUM_REGS(8), .WIDTH(16), .DEAD_CYCLES(1)) u_a (
    .clk(clk), .reset(rst_n), .req_valid(valid_a), .req_ready(ready_a),
    .req_src(src), .req_imm_en(imm_en), .req_imm(imm),
    .req_dst_mask(mask), .DATA(data_a), .reg_enable(en_a),
    .reg_latch(lat_a), .bus_snoop(snoop_a), .busy(busy_a),
    .done(done_a), .err(err_a));

  bus_transfer_ctrl #(.NUM_REGS(6), .WIDTH(16), .DEAD_CYCLES(1)) u_b (
    .clk(clk), .reset(rst_n), .req_valid(valid_b), .req_ready(ready_b),
    .req_src(src), .req_imm_en(imm_en), .req_imm(imm),
    .req_dst_mask(mask[5:0]), .DATA(data_b), .reg_enable(en_b),
    .reg_latch(lat_b), .bus_snoop(snoop_b), .busy(busy_b),
    .done(done_b), .err(err_b));

  bus_transfer_ctrl #(.NUM_REGS(8), .WIDTH(16), .DEAD_CYCLES(2)) u_c (
    .clk(clk), .reset(rst_n), .req_valid(valid_c), .req_ready(ready_c),
    .req_src(src), .req_imm_en(imm_en), .req_imm(imm),
    .req_dst_mask(mask), .DATA(data_c), .reg_enable(en_c),
    .reg_latch(lat_c), .bus_snoop(snoop_c), .busy(busy_c),
    .done(done_c), .err(err_c));

  function automatic logic [7:0][15:0] init_regs();
    logic [7:0][15:0] r;
    for (int i = 0; i < 8; i++) r[i] = 16'hA000 + 16'(i);
    r[2] = 16'h1234;
    return r;
  endfunction

  function automatic logic [15:0] sel(input logic [7:0] en,
                                      input logic [7:0][15:0] r);
    for (int i = 0; i < 8; i++) if (en[i]) return r[i];
    return 16'h0000;
  endfunction

  assign data_a = (en_a != 8'h00) ? sel(en_a, ra) :
                  (keep_a ? 16'h0000 : 16'hzzzz);
  assign data_b = (en_b != 6'h00) ? sel({2'b00, en_b}, rb) : 16'hzzzz;
  assign data_c = (en_c != 8'h00) ? sel(en_c, rc) : 16'hzzzz;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) ra <= init_regs();
    else for (int i = 0; i < 8; i++) if (lat_a[i]) ra[i] <= data_a;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) rb <= init_regs();
    else for (int i = 0; i < 6; i++) if (lat_b[i]) rb[i] <= data_b;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) rc <= init_regs();
    else for (int i = 0; i < 8; i++) if (lat_c[i]) rc[i] <= data_c;

  always @(negedge clk) begin
    if (rst_n) begin
      if ($countones(en_a) > 1 || $countones(en_b) > 1 ||
          $countones(en_c) > 1) viol = viol + 1;
      if (en_a != 8'h00 && data_a !== sel(en_a, ra)) viol = viol + 1;
      if (en_b != 6'h00 && data_b !== sel({2'b00, en_b}, rb)) viol = viol + 1;
      if (en_c != 8'h00 && data_c !== sel(en_c, rc)) viol = viol + 1;
      if (!busy_a && (en_a != 8'h00 || lat_a != 8'h00)) viol = viol + 1;
      if (!busy_c && (en_c != 8'h00 || lat_c != 8'h00)) viol = viol + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic e,
                          input logic [15:0] s);
    exp_t x;
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sbq.size()), 32'd1);
    end else begin
      x = sbq.pop_front();
      chk({tag, "_err"}, 32'(e), 32'(x.err));
      chk({tag, "_snoop"}, 32'(s), 32'(x.snoop));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic saw;
  int cyc, k, ndone, last_acc;
  logic acc;
  logic [2:0] t5_src [3];
  logic t5_imm [3];
  logic [7:0] t5_mask [3];

  initial begin
    rst_n = 1'b0; valid_a = 0; valid_b = 0; valid_c = 0;
    src = 0; imm_en = 0; imm = 0; mask = 0; keep_a = 0;
    step();
    chk("rst_ready", 32'(ready_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    chk("rst_en", 32'(en_a), 32'h00);
    chk("rst_lat", 32'(lat_a), 32'h00);
    chk("rst_snoop", 32'(snoop_a), 32'h0);
    rst_n = 1'b1;
    step();

    // register source, two destinations
    src = 3'd2; imm_en = 0; mask = 8'h30; valid_a = 1;
    sbq.push_back('{err: 1'b0, snoop: 16'h1234});
    step(); valid_a = 0;
    chk("t2_drv_en", 32'(en_a), 32'h04);
    chk("t2_drv_lat", 32'(lat_a), 32'h00);
    chk("t2_drv_busy", 32'(busy_a), 32'd1);
    chk("t2_drv_ready", 32'(ready_a), 32'd0);
    step();
    chk("t2_lat_en", 32'(en_a), 32'h04);
    chk("t2_lat_lat", 32'(lat_a), 32'h30);
    chk("t2_lat_data", 32'(data_a), 32'h1234);
    step();
    chk("t2_turn_en", 32'(en_a), 32'h00);
    chk("t2_done", 32'(done_a), 32'd1);
    sb_check("t2", err_a, snoop_a);
    chk("t2_r4", 32'(ra[4]), 32'h1234);
    chk("t2_r5", 32'(ra[5]), 32'h1234);
    step();
    chk("t2_done_drop", 32'(done_a), 32'd0);
    chk("t2_idle_ready", 32'(ready_a), 32'd1);

    // immediate source
    imm_en = 1; imm = 16'hBEEF; mask = 8'h01; valid_a = 1;
    sbq.push_back('{err: 1'b0, snoop: 16'hBEEF});
    step(); valid_a = 0;
    chk("t3_drv_data", 32'(data_a), 32'hBEEF);
    chk("t3_drv_en", 32'(en_a), 32'h00);
    step();
    chk("t3_lat_data", 32'(data_a), 32'hBEEF);
    chk("t3_lat_lat", 32'(lat_a), 32'h01);
    step();
    keep_a = 1; #1;
    chk("t3_turn_released", 32'(data_a), 32'h0000);
    keep_a = 0;
    chk("t3_done", 32'(done_a), 32'd1);
    sb_check("t3", err_a, snoop_a);
    chk("t3_r0", 32'(ra[0]), 32'hBEEF);
    step();

    // self-destination is masked off
    src = 3'd3; imm_en = 0; mask = 8'h08; valid_a = 1;
    sbq.push_back('{err: 1'b0, snoop: 16'hA003});
    step(); valid_a = 0;
    chk("t4_drv_en", 32'(en_a), 32'h08);
    step();
    chk("t4_lat_lat", 32'(lat_a), 32'h00);
    step();
    chk("t4_done", 32'(done_a), 32'd1);
    sb_check("t4", err_a, snoop_a);
    chk("t4_r3", 32'(ra[3]), 32'hA003);
    step();

    // reset asserted in the middle of LATCH
    src = 3'd1; imm_en = 0; mask = 8'h04; valid_a = 1;
    step(); valid_a = 0;
    step();
    chk("t1_pre_lat", 32'(lat_a), 32'h04);
    #2 rst_n = 1'b0;
    #1 keep_a = 1;
    #1;
    chk("t1_en", 32'(en_a), 32'h00);
    chk("t1_lat", 32'(lat_a), 32'h00);
    chk("t1_released", 32'(data_a), 32'h0000);
    chk("t1_busy", 32'(busy_a), 32'd0);
    keep_a = 0; rst_n = 1'b1;
    saw = 1'b0;
    repeat (4) begin
      step();
      saw = saw | done_a;
    end
    chk("t1_ready", 32'(ready_a), 32'd1);
    chk("t1_no_done", 32'(saw), 32'd0);

    // invalid source on a 6-register instance
    src = 3'd1; imm_en = 0; mask = 8'h01; valid_b = 1;
    sbq.push_back('{err: 1'b0, snoop: 16'hA001});
    step(); valid_b = 0;
    step(); step();
    chk("t6a_done", 32'(done_b), 32'd1);
    sb_check("t6a", err_b, snoop_b);
    step();
    src = 3'd7; imm_en = 0; mask = 8'h3F; valid_b = 1;
    sbq.push_back('{err: 1'b1, snoop: 16'hA001});
    step(); valid_b = 0;
    chk("t6_drv_en", 32'(en_b), 32'h00);
    step();
    chk("t6_lat_en", 32'(en_b), 32'h00);
    chk("t6_lat_lat", 32'(lat_b), 32'h00);
    step();
    chk("t6_done", 32'(done_b), 32'd1);
    sb_check("t6", err_b, snoop_b);
    chk("t6_r0", 32'(rb[0]), 32'hA001);
    chk("t6_r5", 32'(rb[5]), 32'hA005);
    step();
    chk("t6_err_drop", 32'(err_b), 32'd0);

    // back-to-back with DEAD_CYCLES=2
    t5_src = '{3'd1, 3'd0, 3'd6};
    t5_imm = '{1'b0, 1'b1, 1'b0};
    t5_mask = '{8'h80, 8'h02, 8'h41};
    imm = 16'h5A5A;
    sbq.push_back('{err: 1'b0, snoop: 16'hA001});
    sbq.push_back('{err: 1'b0, snoop: 16'h5A5A});
    sbq.push_back('{err: 1'b0, snoop: 16'hA006});
    cyc = 0; k = 0; ndone = 0; last_acc = -1;
    while (ndone < 3 && cyc < 60) begin
      if (k < 3) begin
        src = t5_src[k]; imm_en = t5_imm[k]; mask = t5_mask[k];
        valid_c = 1;
      end else begin
        valid_c = 0;
      end
      acc = valid_c && ready_c;
      step();
      cyc++;
      if (acc) begin
        if (last_acc >= 0) chk("t5_gap", 32'(cyc - last_acc), 32'd5);
        last_acc = cyc;
        k++;
      end
      if (done_c) begin
        ndone++;
        sb_check("t5", err_c, snoop_c);
      end
    end
    valid_c = 0;
    chk("t5_done_count", 32'(ndone), 32'd3);
    chk("t5_r7", 32'(rc[7]), 32'hA001);
    chk("t5_r1", 32'(rc[1]), 32'h5A5A);
    chk("t5_r0", 32'(rc[0]), 32'hA006);

    step();
    chk("contention", 32'(viol), 32'd0);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
